// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key expansion engine.
package aes_pkg;

  typedef enum logic {StIdle, StEmit} ks_state_e;

  localparam int unsigned NUM_WORDS = 44;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // GF(2^8) doubling with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Byte 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_idx;

  assign bit_idx = {~byte_i, 3'b000};
  assign byte_o  = SBOX_TABLE[bit_idx +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion, one round-key word per handshake.
// Define AES_KS_REPLAY_EN to add a 44-word buffer that can re-stream the last full expansion.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [31:0]  rk_word,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [1:0]   rk_col,
  output logic         done
`ifdef AES_KS_REPLAY_EN
  ,
  input  logic         replay
`endif
);

  ks_state_e   state_q;
  logic [5:0]  idx_q;
  logic [7:0]  rcon_q;
  logic [31:0] win_q [4];  // w[idx .. idx+3]
  logic [31:0] rk_word_q;
  logic        rk_valid_q;
  logic        done_q;

  logic        fire;
  logic        last;
  logic        start_replay;
  logic [31:0] replay_word0;
  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] temp_word;
  logic [31:0] gen_word;
  logic [31:0] next_word;

  assign fire     = rk_valid_q & rk_ready;
  assign last     = (idx_q == 6'(NUM_WORDS - 1));
  assign rot_word = {win_q[3][23:0], win_q[3][31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_i (rot_word[8*b +: 8]),
      .byte_o (sub_word[8*b +: 8])
    );
  end

  // The word generated here is w[idx+4], so its column matches idx.
  assign temp_word = (idx_q[1:0] == 2'd0) ? (sub_word ^ {rcon_q, 24'h0}) : win_q[3];
  assign gen_word  = win_q[0] ^ temp_word;

`ifdef AES_KS_REPLAY_EN
  logic [31:0] buf_q [NUM_WORDS];
  logic        buf_valid_q;
  logic        replaying_q;
  logic [5:0]  idx_nxt;

  assign idx_nxt      = idx_q + 6'd1;
  assign next_word    = replaying_q ? buf_q[idx_nxt] : win_q[1];
  assign replay_word0 = buf_q[0];
  assign start_replay = (state_q == StIdle) && !key_valid && replay && buf_valid_q;

  always_ff @(posedge clk) begin
    if (fire && !replaying_q) buf_q[idx_q] <= rk_word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      replaying_q <= 1'b0;
    end else if (state_q == StIdle) begin
      if (key_valid) begin
        buf_valid_q <= 1'b0;
        replaying_q <= 1'b0;
      end else if (start_replay) begin
        replaying_q <= 1'b1;
      end
    end else if (fire && last) begin
      buf_valid_q <= 1'b1;
      replaying_q <= 1'b0;
    end
  end
`else
  assign next_word    = win_q[1];
  assign replay_word0 = 32'h0;
  assign start_replay = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rcon_q     <= RCON[0];
      win_q      <= '{default: '0};
      rk_word_q  <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            state_q    <= StEmit;
            idx_q      <= '0;
            rcon_q     <= RCON[0];
            for (int k = 0; k < 4; k++) win_q[k] <= key_in[127-32*k -: 32];
            rk_word_q  <= key_in[127:96];
            rk_valid_q <= 1'b1;
          end else if (start_replay) begin
            state_q    <= StEmit;
            idx_q      <= '0;
            rk_word_q  <= replay_word0;
            rk_valid_q <= 1'b1;
          end
        end
        StEmit: begin
          if (fire) begin
            if (last) begin
              state_q    <= StIdle;
              idx_q      <= '0;
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_q + 6'd1;
              rk_word_q <= next_word;
              win_q     <= '{win_q[1], win_q[2], win_q[3], gen_word};
              if (idx_q[1:0] == 2'd0) rcon_q <= xtime(rcon_q);
            end
          end
        end
      endcase
    end
  end

  assign key_ready = (state_q == StIdle);
  assign rk_word   = rk_word_q;
  assign rk_valid  = rk_valid_q;
  assign rk_round  = idx_q[5:2];
  assign rk_col    = idx_q[1:0];
  assign done      = done_q;

endmodule
